// File: rtl/sne_pkg.sv
// rtl/sne_pkg.sv - shared types and width helpers for the scheduled netlist executor
package sne_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_NOT = 2'b10,
    OP_BUF = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int instr_w(input int sig_w);
    return 4 + 4 * sig_w;
  endfunction

  localparam int DEF_NUM_SIG = 32;
  localparam int DEF_SIG_W   = idx_w(DEF_NUM_SIG);

  // Field layout of prog_data for the default signal-file depth
  typedef struct packed {
    op_e                  op;
    logic [1:0]           nin;
    logic [DEF_SIG_W-1:0] dst;
    logic [DEF_SIG_W-1:0] src0;
    logic [DEF_SIG_W-1:0] src1;
    logic [DEF_SIG_W-1:0] src2;
  } instr_t;

endpackage

// File: rtl/sne_gate_eval.sv
// rtl/sne_gate_eval.sv - combinational evaluation of one AND/OR/NOT/BUF node
module sne_gate_eval
  import sne_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] nin,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  output logic       result,
  output logic       bad_nin
);

  logic use1;
  logic use2;

  always_comb begin
    bad_nin = (nin == 2'd0);
    use1    = (nin >= 2'd2);
    use2    = (nin == 2'd3);
    result  = 1'b0;
    // Unused sources are forced to the identity value of the operator
    case (op_e'(op))
      OP_AND:  result = s0 & (s1 | ~use1) & (s2 | ~use2);
      OP_OR:   result = s0 | (s1 & use1) | (s2 & use2);
      OP_NOT:  result = ~s0;
      default: result = s0;
    endcase
  end

endmodule

// File: rtl/sched_netlist_exec.sv
// rtl/sched_netlist_exec.sv - executes a programmed gate schedule, one node per clock
// Optional trace outputs (trace_valid/trace_dst/trace_val) under SNE_TRACE_EN.
module sched_netlist_exec
  import sne_pkg::*;
#(
  parameter int NUM_PI  = 6,
  parameter int NUM_PO  = 3,
  parameter int NUM_SIG = 32,
  parameter int NUM_OPS = 16,
  parameter int SIG_W   = idx_w(NUM_SIG),
  parameter int OP_AW   = idx_w(NUM_OPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    prog_we,
  input  logic [OP_AW-1:0]        prog_addr,
  input  logic [4+4*SIG_W-1:0]    prog_data,
  input  logic [OP_AW:0]          prog_len,
  input  logic [NUM_PO*SIG_W-1:0] po_sel,
  input  logic                    pi_valid,
  output logic                    pi_ready,
  input  logic [NUM_PI-1:0]       pi_data,
  output logic                    po_valid,
  input  logic                    po_ready,
  output logic [NUM_PO-1:0]       po_data,
  output logic                    busy,
  output logic                    err
`ifdef SNE_TRACE_EN
  ,
  output logic                    trace_valid,
  output logic [SIG_W-1:0]        trace_dst,
  output logic                    trace_val
`endif
);

  localparam int IW = 4 + 4 * SIG_W;

  state_e               state;
  logic [OP_AW-1:0]     pc;
  logic [OP_AW:0]       len;
  logic [NUM_SIG-1:0]   sig;
  logic [NUM_SIG-1:0]   sig_nxt;
  logic [IW-1:0]        imem [NUM_OPS];
  logic [IW-1:0]        instr;

  logic [1:0]           i_op;
  logic [1:0]           i_nin;
  logic [SIG_W-1:0]     i_dst;
  logic [SIG_W-1:0]     i_src0;
  logic [SIG_W-1:0]     i_src1;
  logic [SIG_W-1:0]     i_src2;
  logic [2:0]           src_bit;
  logic                 g_res;
  logic                 g_bad_nin;
  logic                 dst_bad;
  logic                 wr_en;
  logic                 last_op;
  logic                 len_over;
  logic [OP_AW:0]       len_in;
  logic [NUM_SIG-1:0]   pi_load;

  function automatic logic sig_rd(input logic [NUM_SIG-1:0] v, input logic [SIG_W-1:0] idx);
    return (int'(idx) < NUM_SIG) ? v[idx] : 1'b0;
  endfunction

  function automatic logic [NUM_PO-1:0] pick(input logic [NUM_SIG-1:0] v,
                                             input logic [NUM_PO*SIG_W-1:0] sel);
    logic [NUM_PO-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_PO; k++) begin
      r[k] = sig_rd(v, sel[k*SIG_W +: SIG_W]);
    end
    return r;
  endfunction

  assign instr = imem[pc];
  assign {i_op, i_nin, i_dst, i_src0, i_src1, i_src2} = instr;

  assign src_bit[0] = sig_rd(sig, i_src0);
  assign src_bit[1] = sig_rd(sig, i_src1);
  assign src_bit[2] = sig_rd(sig, i_src2);

  sne_gate_eval u_gate (
    .op      (i_op),
    .nin     (i_nin),
    .s0      (src_bit[0]),
    .s1      (src_bit[1]),
    .s2      (src_bit[2]),
    .result  (g_res),
    .bad_nin (g_bad_nin)
  );

  // Primary-input slots are read-only during execution
  assign dst_bad  = (int'(i_dst) < NUM_PI) || (int'(i_dst) >= NUM_SIG);
  assign wr_en    = (state == EXEC) && !dst_bad;
  assign last_op  = ({1'b0, pc} == (len - 1'b1));
  assign len_over = (int'(prog_len) > NUM_OPS);
  assign len_in   = len_over ? (OP_AW+1)'(NUM_OPS) : prog_len;
  assign pi_load  = {{(NUM_SIG-NUM_PI){1'b0}}, pi_data};

  always_comb begin
    sig_nxt = sig;
    if (wr_en) sig_nxt[i_dst] = g_res;
  end

`ifdef SNE_TRACE_EN
  assign trace_valid = wr_en;
  assign trace_dst   = i_dst;
  assign trace_val   = g_res;
`endif

  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      len      <= '0;
      sig      <= '0;
      pi_ready <= 1'b1;
      po_valid <= 1'b0;
      po_data  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pi_valid && pi_ready) begin
            sig      <= pi_load;
            len      <= len_in;
            pc       <= '0;
            err      <= len_over;
            pi_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= (len_in == '0) ? DONE : EXEC;
          end
        end
        EXEC: begin
          sig <= sig_nxt;
          pc  <= pc + 1'b1;
          if (dst_bad || g_bad_nin) err <= 1'b1;
          if (last_op) state <= DONE;
        end
        DONE: begin
          // First DONE cycle captures the result; handshake only once it is presented
          if (!po_valid) begin
            po_valid <= 1'b1;
            po_data  <= pick(sig, po_sel);
          end else if (po_ready) begin
            po_valid <= 1'b0;
            pi_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sched_netlist_exec.sv
// tb/tb_sched_netlist_exec.sv - scoreboard bench for sched_netlist_exec
`timescale 1ns/1ps
module tb_sched_netlist_exec;

  localparam int NUM_PI  = 6;
  localparam int NUM_PO  = 3;
  localparam int NUM_SIG = 32;
  localparam int NUM_OPS = 16;
  localparam int SIG_W   = 5;
  localparam int OP_AW   = 4;
  localparam int IW      = 4 + 4 * SIG_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    prog_we;
  logic [OP_AW-1:0]        prog_addr;
  logic [IW-1:0]           prog_data;
  logic [OP_AW:0]          prog_len;
  logic [NUM_PO*SIG_W-1:0] po_sel;
  logic                    pi_valid;
  logic                    pi_ready;
  logic [NUM_PI-1:0]       pi_data;
  logic                    po_valid;
  logic                    po_ready;
  logic [NUM_PO-1:0]       po_data;
  logic                    busy;
  logic                    err;
`ifdef SNE_TRACE_EN
  logic                    trace_valid;
  logic [SIG_W-1:0]        trace_dst;
  logic                    trace_val;
`endif

  always #5 clk = ~clk;

  sched_netlist_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .po_sel    (po_sel),
    .pi_valid  (pi_valid),
    .pi_ready  (pi_ready),
    .pi_data   (pi_data),
    .po_valid  (po_valid),
    .po_ready  (po_ready),
    .po_data   (po_data),
    .busy      (busy),
    .err       (err)
`ifdef SNE_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_dst   (trace_dst),
    .trace_val   (trace_val)
`endif
  );

  typedef struct {
    logic [NUM_PO-1:0] po;
    logic              err;
    int                lat;
  } exp_t;

  typedef struct {
    logic [SIG_W-1:0] dst;
    logic             val;
  } trace_t;

  exp_t          sb_q[$];
  trace_t        tr_q[$];
  logic [IW-1:0] mem_m [NUM_OPS];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic prog(input int a, input logic [1:0] op, input logic [1:0] nin,
                      input int d, input int s0, input int s1, input int s2);
    logic [IW-1:0] w;
    w = {op, nin, SIG_W'(d), SIG_W'(s0), SIG_W'(s1), SIG_W'(s2)};
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = OP_AW'(a);
    prog_data = w;
    @(negedge clk);
    prog_we   = 1'b0;
    mem_m[a]  = w;
  endtask

  task automatic set_sel(input int p2, input int p1, input int p0);
    po_sel = {SIG_W'(p2), SIG_W'(p1), SIG_W'(p0)};
  endtask

  // Reference evaluator: runs the model program on a private signal file
  task automatic model(input logic [NUM_PI-1:0] pi, input int plen, output exp_t e);
    logic [NUM_SIG-1:0] s;
    logic [IW-1:0]      w;
    int                 n, op, nin, d;
    logic               a, b, c, r;
    s = '0;
    s[NUM_PI-1:0] = pi;
    e.err = (plen > NUM_OPS);
    n = e.err ? NUM_OPS : plen;
    for (int i = 0; i < n; i++) begin
      w   = mem_m[i];
      op  = int'(w[23:22]);
      nin = int'(w[21:20]);
      d   = int'(w[19:15]);
      a   = s[w[14:10]];
      b   = s[w[9:5]];
      c   = s[w[4:0]];
      if (nin == 0) begin
        e.err = 1'b1;
        nin   = 1;
      end
      if (op == 0)      r = a & ((nin < 2) | b) & ((nin < 3) | c);
      else if (op == 1) r = a | ((nin >= 2) & b) | ((nin == 3) & c);
      else if (op == 2) r = ~a;
      else              r = a;
      if (d < NUM_PI) e.err = 1'b1;
      else begin
        s[d] = r;
        tr_q.push_back('{dst: SIG_W'(d), val: r});
      end
    end
    for (int k = 0; k < NUM_PO; k++) e.po[k] = s[po_sel[k*SIG_W +: SIG_W]];
    e.lat = n + 1;
  endtask

  task automatic run(input logic [NUM_PI-1:0] pi, input int plen, input int hold,
                     input bit poke, input int want);
    exp_t              e;
    exp_t              g;
    int                n;
    logic [NUM_PO-1:0] first;
    model(pi, plen, e);
    @(negedge clk);
    check("pi_ready_idle", pi_ready, 1);
    pi_valid = 1'b1;
    pi_data  = pi;
    prog_len = (OP_AW+1)'(plen);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    pi_valid = 1'b0;
    pi_data  = NUM_PI'($urandom);
    prog_len = (OP_AW+1)'($urandom);
    n = 0;
    while (!po_valid && n < 100) begin
      if (poke && n == 3) begin
        prog_we   = 1'b1;
        prog_addr = OP_AW'($urandom);
        prog_data = IW'($urandom);
      end
      @(posedge clk);
      #1;
      prog_we = 1'b0;
      n++;
    end
    g = sb_q.pop_front();
    if (!po_valid) begin
      check("po_valid_timeout", 0, 1);
      return;
    end
    check("latency", n, g.lat);
    check("po_data", po_data, g.po);
    check("err", err, g.err);
    check("pi_ready_busy", pi_ready, 0);
    check("busy_done", busy, 1);
    if (want >= 0) check("po_plan", po_data, want);
    first = po_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("po_hold", po_data, first);
      check("po_valid_hold", po_valid, 1);
      check("pi_ready_hold", pi_ready, 0);
    end
    po_ready = 1'b1;
    @(posedge clk);
    #1;
    po_ready = 1'b0;
    check("po_valid_drop", po_valid, 0);
    check("pi_ready_back", pi_ready, 1);
    check("busy_clear", busy, 0);
  endtask

`ifdef SNE_TRACE_EN
  always @(negedge clk) begin
    if (rst_n && trace_valid) begin
      if (tr_q.size() == 0) check("trace_extra", 1, 0);
      else begin
        trace_t t;
        t = tr_q.pop_front();
        check("trace_dst", trace_dst, t.dst);
        check("trace_val", trace_val, t.val);
      end
    end
  end
`endif

  initial begin
    exp_t scratch;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    po_sel = '0; pi_valid = 1'b0; pi_data = '0; po_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pi_ready", pi_ready, 1);
    check("rst_po_valid", po_valid, 0);
    check("rst_po_data", po_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sample program over slots 0-16 (a..f = slots 0..5)
    prog(0,  2'b00, 2'd2, 6,  0, 1, 0);
    prog(1,  2'b01, 2'd3, 7,  2, 3, 4);
    prog(2,  2'b10, 2'd1, 8,  5, 0, 0);
    prog(3,  2'b00, 2'd2, 9,  6, 8, 0);
    prog(4,  2'b11, 2'd1, 10, 7, 0, 0);
    prog(5,  2'b01, 2'd2, 11, 9, 10, 0);
    prog(6,  2'b00, 2'd2, 12, 7, 2, 0);
    prog(7,  2'b10, 2'd1, 13, 11, 0, 0);
    prog(8,  2'b01, 2'd2, 14, 12, 13, 0);
    prog(9,  2'b00, 2'd2, 15, 13, 6, 0);
    prog(10, 2'b01, 2'd3, 16, 11, 13, 12);
    set_sel(16, 15, 14);

    run(6'b000011, 11, 0, 1'b0, 3'b100);
    run(6'b010111, 11, 5, 1'b0, 3'b101);
    run(6'b000011, 11, 1, 1'b1, 3'b100);
    run(6'b000011, 11, 0, 1'b0, 3'b100);
    for (int i = 0; i < 4; i++) run(NUM_PI'($urandom), 11, i, 1'b0, -1);

    // Over-length prog_len runs all 16 instructions
    prog(11, 2'b11, 2'd1, 17, 16, 0, 0);
    prog(12, 2'b00, 2'd2, 18, 17, 14, 0);
    prog(13, 2'b01, 2'd3, 19, 18, 15, 8);
    prog(14, 2'b10, 2'd1, 20, 19, 0, 0);
    prog(15, 2'b00, 2'd2, 21, 20, 6, 0);
    set_sel(21, 20, 16);
    run(6'b000011, NUM_OPS + 1, 0, 1'b0, -1);
    run(6'b010111, NUM_OPS + 1, 2, 1'b0, -1);

    // Reset while pc = 5
    model(6'b000011, NUM_OPS + 1, scratch);
    @(negedge clk);
    pi_valid = 1'b1; pi_data = 6'b000011; prog_len = (OP_AW+1)'(NUM_OPS + 1);
    @(posedge clk);
    #1;
    pi_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_err", err, 1);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_pi_ready", pi_ready, 1);
    check("arst_po_valid", po_valid, 0);
    check("arst_po_data", po_data, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    tr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_sel(16, 15, 14);
    run(6'b010111, 11, 0, 1'b0, 3'b101);

    // Zero-length run: outputs follow the freshly loaded slots
    set_sel(20, 3, 0);
    run(6'b001001, 0, 1, 1'b0, 3'b011);
    run(6'b110110, 0, 0, 1'b0, 3'b000);

    // Write to a PI slot is suppressed and flagged
    prog(0, 2'b10, 2'd1, 2, 2, 0, 0);
    prog(1, 2'b11, 2'd1, 6, 2, 0, 0);
    set_sel(6, 2, 0);
    run(6'b000100, 2, 0, 1'b0, 3'b110);
    run(6'b000100, 0, 0, 1'b0, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
